// File: rtl/pc_fetch_unit.sv
// Program counter and fetch/execute sequencer: fetches over a req/ack handshake,
// holds the instruction during execute, then resolves branches and jumps from the ALU flags.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic        en,
    output logic        ifReq,
    output logic [31:0] ifAddr,
    input  logic        ifAck,
    input  logic [31:0] ifData,
    output logic [31:0] instr,
    output logic        instrValid,
    input  logic [5:0]  cuOP,
    input  logic [31:0] imm,
    input  logic [31:0] aluResult,
    input  logic        zero,
    input  logic        execDone,
    output logic [31:0] pc,
    output logic [31:0] pcPlus4,
    output logic        branchTaken,
    output logic        halted,
    output logic        trap
);

    localparam logic [5:0] OP_JAL   = 6'd2;
    localparam logic [5:0] OP_JALR  = 6'd3;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_BLT   = 6'd6;
    localparam logic [5:0] OP_BGE   = 6'd7;
    localparam logic [5:0] OP_BLTU  = 6'd8;
    localparam logic [5:0] OP_BGEU  = 6'd9;
    localparam logic [5:0] OP_ERROR = 6'd38;

    typedef enum logic [1:0] {
        S_FETCH,
        S_EXEC,
        S_HALT
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic        trap_q;
    logic        halted_q;

    logic [31:0] pc_plus4;
    logic [31:0] branch_tgt;
    logic        taken;
    logic [31:0] next_pc_d;
    logic        misaligned;

    always_comb begin
        pc_plus4   = pc_q + 32'd4;
        branch_tgt = pc_q + imm;
        taken      = 1'b0;
        next_pc_d  = pc_plus4;
        case (cuOP)
            OP_JAL:            taken = 1'b1;
            OP_JALR:           taken = 1'b1;
            OP_BEQ:            taken = zero;
            OP_BNE:            taken = ~zero;
            OP_BLT, OP_BLTU:   taken = aluResult[0];
            OP_BGE, OP_BGEU:   taken = ~aluResult[0];
            default:           taken = 1'b0;
        endcase
        if (taken) begin
            next_pc_d = (cuOP == OP_JALR) ? {aluResult[31:1], 1'b0} : branch_tgt;
        end
        misaligned = taken & (|next_pc_d[1:0]);
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q  <= S_FETCH;
            pc_q     <= RESET_PC;
            instr_q  <= '0;
            trap_q   <= 1'b0;
            halted_q <= 1'b0;
        end else if (en) begin
            case (state_q)
                S_FETCH: begin
                    if (ifAck) begin
                        instr_q <= ifData;
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    // ERROR is checked first so it wins over any redirect in the same cycle.
                    if (execDone) begin
                        if (cuOP == OP_ERROR) begin
                            state_q  <= S_HALT;
                            halted_q <= 1'b1;
                        end else if (misaligned) begin
                            state_q  <= S_HALT;
                            halted_q <= 1'b1;
                            trap_q   <= 1'b1;
                        end else begin
                            pc_q    <= next_pc_d;
                            state_q <= S_FETCH;
                        end
                    end
                end
                S_HALT: begin
                    state_q <= S_HALT;
                end
                default: begin
                    state_q <= S_FETCH;
                end
            endcase
        end
    end

    // Request is masked during reset so nothing is issued before the sequencer is live.
    assign ifReq       = nRst & en & (state_q == S_FETCH);
    assign ifAddr      = pc_q;
    assign pc          = pc_q;
    assign pcPlus4     = pc_plus4;
    assign instr       = instr_q;
    assign instrValid  = (state_q == S_EXEC);
    assign branchTaken = taken & (state_q == S_EXEC);
    assign halted      = halted_q;
    assign trap        = trap_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: transaction driver pushes expected fetches/commits into queues,
// a negedge monitor pops and compares whenever a handshake completes.
module tb_pc_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int unsigned OP_ADD = 28;

    logic        clk = 1'b0;
    logic        nRst, en, ifReq, ifAck, zero, execDone;
    logic        instrValid, branchTaken, halted, trap;
    logic [31:0] ifAddr, ifData, instr, imm, aluResult, pc, pcPlus4;
    logic [5:0]  cuOP;

    typedef struct {
        logic        taken;
        logic [31:0] link;
        logic [31:0] ins;
    } exec_t;

    logic [31:0] fetch_q[$];
    exec_t       exec_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] pc_m;
    bit          rand_en = 1'b0;

    pc_fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .nRst(nRst), .en(en),
        .ifReq(ifReq), .ifAddr(ifAddr), .ifAck(ifAck), .ifData(ifData),
        .instr(instr), .instrValid(instrValid),
        .cuOP(cuOP), .imm(imm), .aluResult(aluResult), .zero(zero), .execDone(execDone),
        .pc(pc), .pcPlus4(pcPlus4), .branchTaken(branchTaken),
        .halted(halted), .trap(trap)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void chkb(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void fail_now(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: bound expired at %0t", nm, $time);
    endfunction

    // Reference: direct reading of the branch/jump rules.
    function automatic void model(input int unsigned op, input logic [31:0] cur,
                                  input logic [31:0] im, input logic [31:0] alu, input logic z,
                                  output logic tk, output logic [31:0] nxt,
                                  output bit hlt, output bit trp);
        logic [31:0] dest;
        hlt  = 1'b0;
        trp  = 1'b0;
        dest = cur + im;
        case (op)
            2:       tk = 1'b1;
            3:       begin tk = 1'b1; dest = alu & 32'hFFFF_FFFE; end
            4:       tk = z;
            5:       tk = !z;
            6, 8:    tk = (alu % 2) == 1;
            7, 9:    tk = (alu % 2) == 0;
            default: tk = 1'b0;
        endcase
        if (op == 38) begin
            hlt = 1'b1;
            nxt = cur;
        end else if (tk && (dest % 4) != 0) begin
            hlt = 1'b1;
            trp = 1'b1;
            nxt = cur;
        end else begin
            nxt = tk ? dest : cur + 32'd4;
        end
    endfunction

    always @(negedge clk) begin
        exec_t e;
        if (nRst === 1'b1) begin
            if (ifReq && ifAck) begin
                if (fetch_q.size() == 0) fail_now("unexpected_fetch");
                else chk("fetch_addr", ifAddr, fetch_q.pop_front());
            end
            if (en && instrValid && execDone) begin
                if (exec_q.size() == 0) fail_now("unexpected_commit");
                else begin
                    e = exec_q.pop_front();
                    chkb("commit_branchTaken", branchTaken, e.taken);
                    chk("commit_pcPlus4", pcPlus4, e.link);
                    chk("commit_instr", instr, e.ins);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut(input bit ack_pending);
        if (ack_pending) begin
            ifAck  = 1'b1;
            ifData = 32'hDEAD_BEEF;
        end
        #2 nRst = 1'b0;
        #1;
        chk("rst_pc", pc, RST_PC);
        chk("rst_ifAddr", ifAddr, RST_PC);
        chk("rst_instr", instr, 32'h0);
        chkb("rst_ifReq", ifReq, 1'b0);
        chkb("rst_instrValid", instrValid, 1'b0);
        chkb("rst_halted", halted, 1'b0);
        chkb("rst_trap", trap, 1'b0);
        fetch_q.delete();
        exec_q.delete();
        en       = 1'b1;
        ifAck    = 1'b0;
        execDone = 1'b0;
        step();
        step();
        nRst = 1'b1;
        pc_m = RST_PC;
    endtask

    task automatic halt_checks(input bit exp_trap);
        for (int i = 0; i < 3; i++) begin
            en       = 1'b1;
            ifAck    = 1'b1;
            execDone = 1'b1;
            cuOP     = 6'd2;
            @(negedge clk);
            chkb("halt_halted", halted, 1'b1);
            chkb("halt_trap", trap, exp_trap);
            chk("halt_pc", pc, pc_m);
            chkb("halt_ifReq", ifReq, 1'b0);
            chkb("halt_instrValid", instrValid, 1'b0);
            step();
        end
        execDone = 1'b0;
        ifAck    = 1'b0;
    endtask

    task automatic do_instr(input int unsigned op, input logic [31:0] im, input logic [31:0] alu,
                            input logic z, input int unsigned waits, input int unsigned dwait,
                            input int unsigned en_gap, output int unsigned cycles,
                            output bit hm, output bit tm);
        logic [31:0] data;
        logic [31:0] nxt;
        logic        tk;
        bit          done;
        exec_t       e;
        hm        = 1'b0;
        tm        = 1'b0;
        cycles    = 0;
        data      = $urandom | 32'h1;
        ifData    = data;
        execDone  = 1'b0;
        cuOP      = 6'd2;
        imm       = $urandom;
        aluResult = $urandom;
        zero      = 1'($urandom_range(0, 1));
        fetch_q.push_back(pc_m);
        done = 1'b0;
        for (int unsigned c = 0; c < 64 && !done; c++) begin
            if (c < en_gap) begin
                en    = 1'b0;
                ifAck = 1'b1;
            end else begin
                en    = rand_en ? ($urandom_range(0, 3) != 0) : 1'b1;
                ifAck = (c >= en_gap + waits);
            end
            @(negedge clk);
            chkb("fetch_ifReq", ifReq, en);
            chk("fetch_ifAddr", ifAddr, pc_m);
            chkb("fetch_instrValid", instrValid, 1'b0);
            chkb("fetch_branchTaken", branchTaken, 1'b0);
            chkb("fetch_halted", halted, 1'b0);
            done = en && ifAck;
            step();
            cycles++;
        end
        if (!done) begin
            fail_now("fetch_timeout");
            reset_dut(1'b0);
            return;
        end
        model(op, pc_m, im, alu, z, tk, nxt, hm, tm);
        e.taken = tk;
        e.link  = pc_m + 32'd4;
        e.ins   = data;
        exec_q.push_back(e);
        cuOP      = op[5:0];
        imm       = im;
        aluResult = alu;
        zero      = z;
        done = 1'b0;
        for (int unsigned c = 0; c < 64 && !done; c++) begin
            en       = rand_en ? ($urandom_range(0, 3) != 0) : 1'b1;
            execDone = (c >= dwait);
            ifAck    = 1'($urandom_range(0, 1));
            ifData   = ~data;
            @(negedge clk);
            chkb("exec_instrValid", instrValid, 1'b1);
            chkb("exec_ifReq", ifReq, 1'b0);
            chkb("exec_branchTaken", branchTaken, tk);
            chk("exec_instr", instr, data);
            done = en && execDone;
            step();
            cycles++;
        end
        execDone = 1'b0;
        ifAck    = 1'b0;
        if (!done) begin
            fail_now("exec_timeout");
            reset_dut(1'b0);
            hm = 1'b0;
            return;
        end
        if (!hm) pc_m = nxt;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned cyc;
        bit          hm, tm;
        int unsigned ops[10] = '{0, 2, 3, 4, 5, 6, 7, 8, 9, 28};
        int unsigned op;
        logic [31:0] im, alu;

        nRst = 1'b0; en = 1'b1; ifAck = 1'b1; ifData = 32'h1234_5678;
        execDone = 1'b0; cuOP = 6'd2; imm = '0; aluResult = '0; zero = 1'b0;
        @(negedge clk);
        chk("init_pc", pc, RST_PC);
        chk("init_instr", instr, 32'h0);
        chkb("init_ifReq", ifReq, 1'b0);
        chkb("init_halted", halted, 1'b0);
        chkb("init_trap", trap, 1'b0);
        step();
        ifAck = 1'b0;
        nRst  = 1'b1;
        pc_m  = RST_PC;

        for (int i = 0; i < 4; i++) begin
            do_instr(OP_ADD, 32'h0, 32'h0, 1'b0, 0, 0, 0, cyc, hm, tm);
            chk("period", cyc, 32'd2);
        end
        do_instr(2, 32'h0000_00F0, 32'h0, 1'b0, 0, 0, 0, cyc, hm, tm);
        do_instr(4, 32'hFFFF_FFF0, 32'h0, 1'b1, 0, 0, 0, cyc, hm, tm);
        do_instr(2, 32'h0000_0010, 32'h0, 1'b0, 0, 0, 0, cyc, hm, tm);
        do_instr(4, 32'hFFFF_FFF0, 32'h0, 1'b0, 0, 0, 0, cyc, hm, tm);
        do_instr(8, 32'h0000_0008, 32'h1, 1'b0, 0, 0, 0, cyc, hm, tm);
        do_instr(9, 32'h0000_0008, 32'h1, 1'b0, 0, 0, 0, cyc, hm, tm);
        do_instr(2, 32'hFFFF_FF30, 32'h0, 1'b0, 0, 0, 0, cyc, hm, tm);
        do_instr(2, 32'h0000_0020, 32'h0, 1'b0, 0, 0, 0, cyc, hm, tm);
        do_instr(3, 32'h0, 32'h0000_2001, 1'b0, 0, 0, 0, cyc, hm, tm);
        do_instr(OP_ADD, 32'h0, 32'h0, 1'b0, 3, 1, 0, cyc, hm, tm);
        do_instr(OP_ADD, 32'h0, 32'h0, 1'b0, 0, 0, 2, cyc, hm, tm);
        do_instr(3, 32'h0, 32'hFFFF_FFFD, 1'b0, 0, 0, 0, cyc, hm, tm);
        do_instr(OP_ADD, 32'h0, 32'h0, 1'b0, 0, 0, 0, cyc, hm, tm);
        do_instr(OP_ADD, 32'h0, 32'h0, 1'b0, 0, 0, 0, cyc, hm, tm);

        do_instr(38, 32'h0, 32'h0, 1'b0, 0, 0, 0, cyc, hm, tm);
        halt_checks(1'b0);
        reset_dut(1'b0);

        do_instr(2, 32'h0000_0010, 32'h0, 1'b0, 0, 0, 0, cyc, hm, tm);
        do_instr(5, 32'h0000_0006, 32'h0, 1'b0, 0, 0, 0, cyc, hm, tm);
        halt_checks(1'b1);
        reset_dut(1'b0);

        do_instr(OP_ADD, 32'h0, 32'h0, 1'b0, 0, 0, 0, cyc, hm, tm);
        reset_dut(1'b1);
        do_instr(OP_ADD, 32'h0, 32'h0, 1'b0, 0, 0, 0, cyc, hm, tm);
        do_instr(OP_ADD, 32'h0, 32'h0, 1'b0, 0, 0, 0, cyc, hm, tm);

        rand_en = 1'b1;
        for (int i = 0; i < 80; i++) begin
            op = ($urandom_range(0, 24) == 0) ? 38 : ops[$urandom_range(0, 9)];
            im = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0) im = im | 32'($urandom_range(1, 3));
            alu = $urandom;
            if (op == 3 && $urandom_range(0, 3) != 0) alu = alu & 32'hFFFF_FFFD;
            do_instr(op, im, alu, 1'($urandom_range(0, 1)),
                     $urandom_range(0, 2), $urandom_range(0, 2), 0, cyc, hm, tm);
            if (hm) begin
                halt_checks(tm);
                reset_dut(1'b0);
            end
        end

        chk("fetch_q_drained", 32'(fetch_q.size()), 32'd0);
        chk("exec_q_drained", 32'(exec_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Program-counter and instruction-fetch sequencer for the RISC-V core: owns the PC register and fetches each instruction over a req/ack handshake. It holds the instruction while the execute stage runs. It then consumes the ALU's result/zero outputs to resolve branches and jumps and advance the PC. It sits on the consuming side of the ALU's flag/result interface, between instruction memory and the control unit.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- nRst  in  1  asynchronous, active-low reset.
- en  in  1  global enable; 0 freezes all state and masks ifReq.
- ifReq  out  1  fetch request.
- ifAddr  out  32  fetch address; always equals pc.
- ifAck  in  1  memory accepts the request; ifData is valid in the same cycle.
- ifData  in  32  fetched instruction word.
- instr  out  32  latched instruction.
- instrValid  out  1  high while in EXEC.
- cuOP  in  6  decoded op, control-unit enum encoding: JAL=2, JALR=3, BEQ=4, BNE=5, BLT=6, BGE=7, BLTU=8, BGEU=9, ERROR=38.
- imm  in  32  sign-extended branch/JAL offset.
- aluResult  in  32  ALU result; the ALU performs SLT/SLTU for BLT/BGE/BLTU/BGEU and ADD for JALR.
- zero  in  1  ALU zero flag; the ALU performs SUB for BEQ/BNE.
- execDone  in  1  execute stage complete; commit next PC.
- pc  out  32  current PC.
- pcPlus4  out  32  pc+4, the link value for JAL/JALR.
- branchTaken  out  1  redirect taken for the current instruction (EXEC only).
- halted  out  1  sticky halt.
- trap  out  1  sticky misaligned-target flag.

## Operation
- States: FETCH, EXEC, HALT.
- FETCH: ifReq = en. On an edge with en & ifAck: instr <= ifData, go to EXEC.
- EXEC: instr is held and instrValid=1. On an edge with en & execDone:
  - If cuOP==ERROR: go to HALT, pc unchanged, trap=0.
  - Else if taken and target[1:0]!=0: go to HALT, trap<=1, pc unchanged.
  - Else: pc <= nextPc, go to FETCH.
- HALT: absorbing state. ifReq=0, instrValid=0. Left only by reset.
- Target selection, all 32-bit modulo-2^32 arithmetic with wraparound:
  - BEQ: taken = zero.
  - BNE: taken = !zero.
  - BLT/BLTU: taken = aluResult[0].
  - BGE/BGEU: taken = !aluResult[0].
  - Branch target = pc+imm.
  - JAL: always taken, target = pc+imm.
  - JALR: always taken, target = {aluResult[31:1],1'b0}. The JALR target is never misaligned in bit 0. It traps only if bit 1 is set.
  - Any other cuOP: not taken, nextPc = pc+4.
- branchTaken = taken & (state==EXEC). It is combinational.
- Outputs pc, pcPlus4 and ifAddr are combinational from the pc register.
- ifAck while ifReq=0 (EXEC, HALT, en=0) is ignored.

## Timing
- Reset (asynchronous, any state, including mid-fetch) drives:
  - pc=RESET_PC, state=FETCH.
  - instr=0, trap=0, halted=0.
  - ifReq=0 while nRst=0.
- First request: ifReq rises in the first cycle after nRst deasserts, provided en=1.
- Zero-wait fetch: ack in the same cycle as req means EXEC in the next cycle. Fetch latency is 1 + wait cycles.
- Minimum instruction period is 2 cycles: one FETCH cycle and one EXEC cycle with execDone tied high.
- en=0 holds all state. ifReq drops in the same cycle. A pending fetch resumes when en returns to 1.
- Simultaneous execDone and ERROR: ERROR wins, go to HALT.
- halted is asserted in the cycle after the HALT transition.
- pc wrap: pc=32'hFFFF_FFFC with a non-branch op gives nextPc=0. This does not trap.

## Test plan
- Reset then sequential fetch: RESET_PC=0, ifAck tied high, execDone=1, cuOP=ADD (28) -> ifAddr sequence 0,4,8,12 with a 2-cycle period. instr follows ifData.
- Branches:
  - pc=0x100, BEQ, zero=1, imm=0xFFFFFFF0 -> branchTaken=1, next ifAddr=0xF0.
  - Same with zero=0 -> next ifAddr=0x104.
  - BLTU with aluResult=1 -> taken.
  - BGEU with aluResult=1 -> not taken.
- Jumps:
  - pc=0x40, JAL, imm=0x20 -> next ifAddr=0x60, pcPlus4=0x44 during EXEC.
  - JALR, aluResult=0x2001 -> next ifAddr=0x2000.
- Wait states and enable:
  - ifAck held low 3 cycles -> ifReq stays high and ifAddr stable, then EXEC.
  - en=0 mid-FETCH -> ifReq=0 and an ack is ignored. Resumes on en=1.
- Halt/trap:
  - BNE taken, pc=0x10, imm=0x6 -> halted=1, trap=1, pc stays 0x10, no further ifReq.
  - cuOP=38 -> halted=1, trap=0.
  - nRst pulse -> pc=RESET_PC, fetch resumes.
- Async reset mid-fetch with ifAck pending -> instr=0, state FETCH, pc=RESET_PC immediately, not waiting for a clock edge.
